// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem requests,
// one-entry output register with valid/ready, and branch/jump redirects.
module fetch_unit #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            redirect_valid,
    input  logic [2:0]      branch_cond,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] branch_target
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            discard;
    logic            slot_free;
    logic            grant;
    logic            load;
    logic            taken;

    always_comb begin
        taken = 1'b0;
        if (redirect_valid) begin
            unique case (branch_cond)
                3'b000:  taken = alu_zero;
                3'b001:  taken = !alu_zero;
                3'b011:  taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    assign slot_free = !instr_valid || instr_ready;
    assign grant     = imem_req && imem_gnt;
    assign load      = (state == WAIT) && imem_rvalid && !discard;
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req = slot_free;
                if (slot_free && imem_gnt) state_next = WAIT;
            end
            WAIT: if (imem_rvalid) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_pc      <= '0;
            discard     <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
        end else begin
            state <= state_next;
            if (grant) req_pc <= pc;

            // A redirect kills both the current output and any same-cycle load.
            if (taken) begin
                pc          <= {branch_target[XLEN-1:2], 2'b00};
                instr_valid <= 1'b0;
            end else if (load) begin
                instr_out   <= imem_rdata;
                pc_out      <= req_pc;
                instr_valid <= 1'b1;
                pc          <= req_pc + XLEN'(PC_STEP);
            end else if (instr_ready) begin
                instr_valid <= 1'b0;
            end

            // Only mark for discard when a response is still outstanding after this edge.
            if (taken && (((state == WAIT) && !imem_rvalid) || grant))
                discard <= 1'b1;
            else if ((state == WAIT) && imem_rvalid)
                discard <= 1'b0;
        end
    end

    assign opcode = instr_out[6:0];
    assign funct3 = instr_out[14:12];
    assign funct7 = instr_out[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        redirect_valid = 1'b0;
    logic [2:0]  branch_cond = 3'b010;
    logic        alu_zero = 1'b0;
    logic [31:0] branch_target = '0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .redirect_valid(redirect_valid), .branch_cond(branch_cond),
        .alu_zero(alu_zero), .branch_target(branch_target)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .instr_out(w_instr), .pc_out(w_pc),
        .opcode(w_op), .funct3(w_f3), .funct7(w_f7),
        .redirect_valid(redirect_valid), .branch_cond(branch_cond),
        .alu_zero(alu_zero), .branch_target(branch_target)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F13;
    endfunction

    function automatic bit br_taken(input logic rv, input logic [2:0] c, input logic z);
        if (!rv) return 1'b0;
        case (c)
            3'b000:  return z;
            3'b001:  return !z;
            3'b011:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Transaction-level model: PC, one outstanding fetch, output slot.
    bit          m_known = 0;
    bit          m_idle, m_busy, m_drop, m_v;
    logic [31:0] m_pc, m_reqaddr, m_instr, m_pcout;

    always @(posedge clk) begin
        bit tk, issue, got;
        if (reset) begin
            m_known = 1; m_idle = 1; m_busy = 0; m_drop = 0; m_v = 0;
            m_pc = 32'h0; m_reqaddr = 0; m_instr = 0; m_pcout = 0;
        end else if (m_known) begin
            tk    = br_taken(redirect_valid, branch_cond, alu_zero);
            issue = !m_idle && !m_busy && (!m_v || instr_ready) && imem_gnt;
            got   = m_busy && imem_rvalid;
            if (instr_ready) m_v = 0;
            if (got && !m_drop && !tk) begin
                m_v = 1;
                m_instr = mem_word(m_reqaddr);
                m_pcout = m_reqaddr;
                m_pc = m_reqaddr + 32'd4;
            end
            if (got) begin m_busy = 0; m_drop = 0; end
            if (issue) begin m_busy = 1; m_drop = 0; m_reqaddr = m_pc; end
            if (tk) begin
                m_pc = {branch_target[31:2], 2'b00};
                m_v = 0;
                if (m_busy) m_drop = 1;
            end
            m_idle = 0;
        end
    end

    always @(negedge clk) begin
        bit exp_req;
        if (m_known) begin
            exp_req = !m_idle && !m_busy && (!m_v || instr_ready);
            check("model.imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("model.imem_addr", imem_addr, m_pc);
            check("model.instr_valid", 32'(instr_valid), 32'(m_v));
            check("model.instr_out", instr_out, m_instr);
            check("model.pc_out", pc_out, m_pcout);
            check("model.opcode", 32'(opcode), 32'(m_instr[6:0]));
            check("model.funct3", 32'(funct3), 32'(m_instr[14:12]));
            check("model.funct7", 32'(funct7), 32'(m_instr[31:25]));
        end
    end

    // Memory responder: grant is a plain input, response after lat cycles.
    int          lat = 1;
    bit          force_rv = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    task automatic step();
        logic fire, rst_s;
        logic [31:0] faddr;
        #1;
        fire = imem_req && imem_gnt;
        faddr = imem_addr;
        rst_s = reset;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_rvalid = 1'b0;
        if (rst_s) pend = 0;
        else if (fire) begin pend = 1; cnt = lat; paddr = faddr; end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = mem_word(paddr); pend = 0; end
        end
        if (force_rv) begin imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
        #1;
    endtask

    task automatic redirect(input logic [2:0] c, input logic z, input logic [31:0] t);
        redirect_valid = 1'b1; branch_cond = c; alu_zero = z; branch_target = t;
    endtask

    initial begin
        logic [31:0] w;
        // Zero-wait streaming, plus the wrap-around instance alongside.
        reset = 1'b1; step(); step();
        reset = 1'b0; step();
        for (int unsigned i = 0; i < 4; i++) begin
            check("seq.req", 32'(imem_req), 32'd1);
            check("seq.addr", imem_addr, 32'(4 * i));
            if (i > 0) begin
                w = mem_word(32'(4 * (i - 1)));
                check("seq.valid", 32'(instr_valid), 32'd1);
                check("seq.pc_out", pc_out, 32'(4 * (i - 1)));
                check("seq.opcode", 32'(opcode), 32'(w[6:0]));
                check("seq.funct3", 32'(funct3), 32'(w[14:12]));
                check("seq.funct7", 32'(funct7), 32'(w[31:25]));
            end
            if (i == 0) check("wrap.addr0", w_addr, 32'hFFFF_FFFC);
            if (i == 1) begin
                check("wrap.valid", 32'(w_valid), 32'd1);
                check("wrap.pc_out", w_pc, 32'hFFFF_FFFC);
                check("wrap.addr1", w_addr, 32'h0);
            end
            step(); step();
        end

        // Backpressure.
        reset = 1'b1; step();
        reset = 1'b0; step();
        check("bp.addr0", imem_addr, 32'h0);
        step();
        instr_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check("bp.valid", 32'(instr_valid), 32'd1);
            check("bp.instr", instr_out, mem_word(32'h0));
            check("bp.pc_out", pc_out, 32'h0);
            check("bp.noreq", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        lat = 2;
        #1;
        check("bp.req", 32'(imem_req), 32'd1);
        check("bp.addr4", imem_addr, 32'h4);
        step();

        // Taken beq during WAIT; response discarded.
        redirect(3'b000, 1'b1, 32'h103);
        step();
        check("beq.valid", 32'(instr_valid), 32'd0);
        check("beq.noreq", 32'(imem_req), 32'd0);
        step();
        check("beq.valid2", 32'(instr_valid), 32'd0);
        check("beq.addr", imem_addr, 32'h100);
        lat = 1;
        redirect(3'b000, 1'b0, 32'h200);
        step(); step();
        check("beqnt.valid", 32'(instr_valid), 32'd1);
        check("beqnt.pc_out", pc_out, 32'h100);
        check("beqnt.addr", imem_addr, 32'h104);

        // Redirects coinciding with rvalid.
        step();
        redirect(3'b001, 1'b0, 32'h300);
        step();
        check("bne.valid", 32'(instr_valid), 32'd0);
        check("bne.addr", imem_addr, 32'h300);
        step();
        redirect(3'b011, 1'b1, 32'h400);
        step();
        check("jmp.valid", 32'(instr_valid), 32'd0);
        check("jmp.addr", imem_addr, 32'h400);
        step();
        redirect(3'b010, 1'b1, 32'h500);
        step();
        check("none.valid", 32'(instr_valid), 32'd1);
        check("none.pc_out", pc_out, 32'h400);
        check("none.addr", imem_addr, 32'h404);

        // Redirect in REQ without grant moves the pending address.
        imem_gnt = 1'b0;
        redirect(3'b011, 1'b0, 32'h603);
        step();
        check("nognt.addr", imem_addr, 32'h600);
        check("nognt.valid", 32'(instr_valid), 32'd0);
        imem_gnt = 1'b1;
        step(); step();
        check("nognt.pc_out", pc_out, 32'h600);

        // Reset while a response is arriving, and one cycle later.
        step();
        reset = 1'b1; force_rv = 1'b1;
        step();
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.noreq", 32'(imem_req), 32'd0);
        reset = 1'b0; force_rv = 1'b0;
        step();
        check("rst.valid2", 32'(instr_valid), 32'd0);
        check("rst.addr", imem_addr, 32'h0);
        step(); step();
        check("rst.pc_out", pc_out, 32'h0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
